// File: rtl/i2f_share_sched.sv
// Round-robin scheduler sharing one int32 -> IEEE-754 single conversion stage among NUM_REQ
// requesters; results are tagged with the requester index and held until consumed.
module i2f_share_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TAG_W   = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    res_valid,
    output logic [31:0]             res_data,
    output logic                    res_plost,
    output logic [TAG_W-1:0]        res_tag,
    input  logic                    res_ready,
    output logic                    busy,
    output logic [CNT_W-1:0]        plost_cnt,
    input  logic                    plost_clr
);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [31:0]        op_q, op_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [31:0]        res_data_q, res_data_d;
    logic               res_plost_q, res_plost_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;
    logic [CNT_W-1:0]   plost_cnt_q, plost_cnt_d;

    logic               accept;
    logic               found;
    logic               grant;
    logic [TAG_W-1:0]   grant_idx;
    logic [TAG_W:0]     grant_sum;
    logic [NUM_REQ-1:0] rot_valid;
    logic [31:0]        sel_data;

    logic               conv_sign;
    logic [31:0]        conv_mag;
    logic [4:0]         conv_lz;
    logic               lz_found;
    logic [31:0]        conv_norm;
    logic [7:0]         conv_exp;
    logic [31:0]        conv_data;
    logic               conv_plost;

    assign accept = (state_q == StIdle) || ((state_q == StDone) && res_ready);

    // Rotate valids so bit 0 is rr_ptr; the first set bit is the grant offset.
    always_comb begin
        rot_valid = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
        found     = 1'b0;
        grant_sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot_valid[k]) begin
                found     = 1'b1;
                grant_sum = {1'b0, rr_ptr_q} + (TAG_W+1)'(k);
            end
        end
        if (grant_sum >= (TAG_W+1)'(NUM_REQ)) begin
            grant_sum = grant_sum - (TAG_W+1)'(NUM_REQ);
        end
        grant_idx = grant_sum[TAG_W-1:0];
    end

    assign grant = accept && found && !rst;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (TAG_W'(i) == grant_idx) begin
                sel_data = req_data[32*i +: 32];
            end
        end
    end

    // Conversion: normalise magnitude, truncate fraction, flag any dropped bits.
    always_comb begin
        conv_sign = op_q[31];
        conv_mag  = conv_sign ? (32'd0 - op_q) : op_q;
        conv_lz   = '0;
        lz_found  = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!lz_found && conv_mag[i]) begin
                lz_found = 1'b1;
                conv_lz  = 5'(31 - i);
            end
        end
        conv_norm  = conv_mag << conv_lz;
        conv_exp   = 8'd158 - {3'b000, conv_lz};
        conv_data  = (op_q == 32'd0) ? 32'd0 : {conv_sign, conv_exp, conv_norm[30:8]};
        conv_plost = (op_q != 32'd0) && (|conv_norm[7:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            op_q        <= '0;
            tag_q       <= '0;
            res_data_q  <= '0;
            res_plost_q <= 1'b0;
            res_tag_q   <= '0;
            plost_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            tag_q       <= tag_d;
            res_data_q  <= res_data_d;
            res_plost_q <= res_plost_d;
            res_tag_q   <= res_tag_d;
            plost_cnt_q <= plost_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant) state_d = StConv;
            StConv:  state_d = StDone;
            StDone:  if (res_ready) state_d = grant ? StConv : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        op_d        = op_q;
        tag_d       = tag_q;
        res_data_d  = res_data_q;
        res_plost_d = res_plost_q;
        res_tag_d   = res_tag_q;
        plost_cnt_d = plost_cnt_q;
        if (grant) begin
            op_d     = sel_data;
            tag_d    = grant_idx;
            rr_ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
        if (state_q == StConv) begin
            res_data_d  = conv_data;
            res_plost_d = conv_plost;
            res_tag_d   = tag_q;
        end
        if (plost_clr) begin
            plost_cnt_d = '0;
        end else if (res_valid && res_ready && res_plost_q && (plost_cnt_q != '1)) begin
            plost_cnt_d = plost_cnt_q + 1'b1;
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready = NUM_REQ'(1) << grant_idx;
        end
        busy      = (state_q != StIdle);
        res_valid = (state_q == StDone);
        res_data  = res_data_q;
        res_plost = res_plost_q;
        res_tag   = res_tag_q;
        plost_cnt = plost_cnt_q;
    end

endmodule

// File: tb/tb_i2f_share_sched.sv
// Directed bench for i2f_share_sched: table of conversions plus hand-written arbitration,
// backpressure, counter and reset sequences.
module tb_i2f_share_sched;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned TAG_W   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  res_valid;
    logic [31:0]           res_data;
    logic                  res_plost;
    logic [TAG_W-1:0]      res_tag;
    logic                  res_ready;
    logic                  busy;
    logic [15:0]           plost_cnt;
    logic                  plost_clr;

    logic [NUM_REQ-1:0]    s_req_ready;
    logic                  s_res_valid;
    logic [31:0]           s_res_data;
    logic                  s_res_plost;
    logic [TAG_W-1:0]      s_res_tag;
    logic                  s_busy;
    logic [1:0]            s_plost_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt;
    int exp_small;

    typedef struct {
        int unsigned req;
        logic [31:0] d;
        logic [31:0] res;
        logic        pl;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    i2f_share_sched #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .CNT_W(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_plost (res_plost),
        .res_tag   (res_tag),
        .res_ready (res_ready),
        .busy      (busy),
        .plost_cnt (plost_cnt),
        .plost_clr (plost_clr)
    );

    // Narrow-counter instance sees identical stimulus to exercise saturation.
    i2f_share_sched #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .CNT_W(2)) u_dut_sat (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (s_req_ready),
        .res_valid (s_res_valid),
        .res_data  (s_res_data),
        .res_plost (s_res_plost),
        .res_tag   (s_res_tag),
        .res_ready (res_ready),
        .busy      (s_busy),
        .plost_cnt (s_plost_cnt),
        .plost_clr (plost_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnts(input string name);
        chk({name, "_cnt"}, 32'(plost_cnt), exp_cnt);
        chk({name, "_cnt_sat"}, 32'(s_plost_cnt), exp_small);
    endtask

    // Starts mid-cycle with the DUT idle; returns mid-cycle with the DUT idle again.
    task automatic run_txn(input int unsigned r, input logic [31:0] d, input logic [31:0] exp,
                           input logic exp_pl, input logic clr);
        req_valid = '0;
        req_valid[r] = 1'b1;
        req_data[32*r +: 32] = d;
        res_ready = 1'b1;
        #1;
        chk("txn_ready", 32'(req_ready), 32'(1) << r);
        tick();
        req_valid = '0;
        #1;
        chk("txn_conv_valid", 32'(res_valid), 32'd0);
        chk("txn_conv_busy", 32'(busy), 32'd1);
        tick();
        plost_clr = clr;
        #1;
        chk("txn_valid", 32'(res_valid), 32'd1);
        chk("txn_data", res_data, exp);
        chk("txn_plost", 32'(res_plost), 32'(exp_pl));
        chk("txn_tag", 32'(res_tag), r);
        if (clr) begin
            exp_cnt   = 0;
            exp_small = 0;
        end else if (exp_pl) begin
            if (exp_cnt < 65535) exp_cnt++;
            if (exp_small < 3) exp_small++;
        end
        tick();
        plost_clr = 1'b0;
        #1;
        chk("txn_idle", 32'(busy), 32'd0);
        chk_cnts("txn");
    endtask

    initial begin
        int grants;
        int rr_exp;
        int tag_exp;

        vecs[0] = '{req: 0, d: 32'h0000_0001, res: 32'h3F80_0000, pl: 1'b0};
        vecs[1] = '{req: 1, d: 32'hFFFF_FFFF, res: 32'hBF80_0000, pl: 1'b0};
        vecs[2] = '{req: 1, d: 32'h8000_0000, res: 32'hCF00_0000, pl: 1'b0};
        vecs[3] = '{req: 1, d: 32'h0000_0000, res: 32'h0000_0000, pl: 1'b0};
        vecs[4] = '{req: 1, d: 32'h7FFF_FFFF, res: 32'h4EFF_FFFF, pl: 1'b1};
        vecs[5] = '{req: 2, d: 32'h0100_0001, res: 32'h4B80_0000, pl: 1'b1};
        vecs[6] = '{req: 3, d: 32'h0000_0003, res: 32'h4040_0000, pl: 1'b0};
        vecs[7] = '{req: 2, d: 32'hFFFF_FFFD, res: 32'hC040_0000, pl: 1'b0};

        rst       = 1'b1;
        req_valid = '1;
        req_data  = '0;
        res_ready = 1'b0;
        plost_clr = 1'b0;
        exp_cnt   = 0;
        exp_small = 0;
        #2;
        chk("reset_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        chk("reset_ready2", 32'(req_ready), 32'd0);
        chk("reset_valid", 32'(res_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_data", res_data, 32'd0);
        chk("reset_tag", 32'(res_tag), 32'd0);
        chk_cnts("reset");
        req_valid = '0;
        rst = 1'b0;
        #1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].req, vecs[i].d, vecs[i].res, vecs[i].pl, 1'b0);
        end

        // plost_cnt: clear, count three, clear on a consume, then saturate the narrow one.
        plost_clr = 1'b1;
        tick();
        plost_clr = 1'b0;
        exp_cnt   = 0;
        exp_small = 0;
        #1;
        chk_cnts("clr_idle");
        for (int i = 0; i < 3; i++) run_txn(i, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 1'b1, 1'b0);
        chk("cnt_three", 32'(plost_cnt), 32'd3);
        run_txn(3, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 1'b1, 1'b1);
        chk("cnt_clr_prio", 32'(plost_cnt), 32'd0);
        for (int i = 0; i < 5; i++) run_txn(i % 4, 32'h0100_0001, 32'h4B80_0000, 1'b1, 1'b0);
        chk("cnt_five", 32'(plost_cnt), 32'd5);
        chk("cnt_sat", 32'(s_plost_cnt), 32'd3);

        // Backpressure with requester 1 waiting behind requester 0.
        req_valid = 4'b0001;
        req_data[31:0] = 32'h0100_0001;
        req_data[63:32] = 32'h0000_0003;
        res_ready = 1'b0;
        #1;
        chk("bp_grant0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0010;
        #1;
        chk("bp_conv_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 32'(res_valid), 32'd1);
            chk("bp_hold_data", res_data, 32'h4B80_0000);
            chk("bp_hold_plost", 32'(res_plost), 32'd1);
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_consume_grant", 32'(req_ready), 32'h2);
        if (exp_cnt < 65535) exp_cnt++;
        if (exp_small < 3) exp_small++;
        tick();
        req_valid = '0;
        #1;
        chk("bp_conv_valid", 32'(res_valid), 32'd0);
        chk("bp_conv_busy", 32'(busy), 32'd1);
        chk_cnts("bp");
        tick();
        chk("bp_next_data", res_data, 32'h4040_0000);
        chk("bp_next_tag", 32'(res_tag), 32'd1);
        tick();
        chk("bp_drain", 32'(busy), 32'd0);

        // Reset while requester 2 is in CONV.
        req_valid = 4'b0100;
        req_data[95:64] = 32'h0000_0005;
        #1;
        chk("rst_grant2", 32'(req_ready), 32'h4);
        tick();
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("rst_cycle_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        req_valid = '0;
        exp_cnt   = 0;
        exp_small = 0;
        #1;
        chk("rst_mid_valid", 32'(res_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_data", res_data, 32'd0);
        chk_cnts("rst_mid");
        req_valid = 4'b1111;
        #1;
        chk("rst_rrptr0", 32'(req_ready), 32'h1);
        run_txn(2, 32'h0000_0005, 32'h40A0_0000, 1'b0, 1'b0);

        // Round robin with all requesters valid; rr_ptr is 3 here, so reset first.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) req_data[32*i +: 32] = 32'(i + 1);
        req_valid = 4'b1111;
        res_ready = 1'b1;
        grants  = 0;
        tag_exp = 0;
        #1;
        for (int c = 0; c < 20 && grants < 5; c++) begin
            chk("rr_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (res_valid) begin
                chk("rr_tag", 32'(res_tag), 32'(tag_exp));
                tag_exp = (tag_exp + 1) % 4;
            end
            if (req_ready != '0) begin
                rr_exp = grants % 4;
                chk("rr_order", 32'(req_ready), 32'(1) << rr_exp);
                grants++;
            end
            tick();
        end
        chk("rr_grant_count", 32'(grants), 32'd5);
        req_valid = '0;
        tick();
        chk("rr_last_tag", 32'(res_tag), 32'd0);
        chk("rr_last_valid", 32'(res_valid), 32'd1);
        tick();
        chk("rr_drain", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2f_share_sched.md
Name: i2f_share_sched

Overview:
- Round-robin scheduler that shares one integer-to-float conversion datapath among NUM_REQ requesters.
- Each requester presents a 32-bit two's-complement integer with a valid/ready handshake.
- The block accepts one operand at a time, converts it in a dedicated pipeline stage, and returns the IEEE-754 single-precision result tagged with the requester index.
- Sits between the integer execution clients and the floating-point result bus.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TAG_W, 2, width of requester tag; must equal ceil(log2(NUM_REQ)).
- CNT_W, 16, width of the saturating precision-lost event counter.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_data  input  32*NUM_REQ  operands; requester i uses bits [32i+31:32i].
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
- res_valid  output  1  result valid.
- res_data  output  32  float result.
- res_plost  output  1  precision lost on this result.
- res_tag  output  TAG_W  index of originating requester.
- res_ready  input  1  consumer accepts result.
- busy  output  1  high in any state other than IDLE.
- plost_cnt  output  CNT_W  count of delivered results with res_plost=1; saturates at all-ones.
- plost_clr  input  1  clears plost_cnt.

Behaviour:
- Reset (rst=1 at clock edge) forces the following, regardless of the operation in flight; any in-flight operand or result is discarded:
  - state=IDLE, rr_ptr=0, plost_cnt=0.
  - res_valid=0, res_data=0, res_plost=0, res_tag=0.
  - req_ready=0 during the reset cycle.
- States are IDLE, CONV and DONE.
- Accept condition: state==IDLE, or state==DONE && res_ready.
- Arbitration:
  - When the accept condition holds and any req_valid is high, grant the lowest index j >= rr_ptr with req_valid[j], wrapping modulo NUM_REQ.
  - req_ready[j]=1 combinationally in that cycle; all other req_ready bits are 0.
  - At the edge: latch the operand and tag j, set rr_ptr=(j+1) mod NUM_REQ, go to CONV.
  - With no valid request: IDLE stays IDLE, and DONE with res_ready goes to IDLE.
- CONV (exactly one cycle):
  - Compute the conversion from the latched operand and register it into res_data, res_plost and res_tag.
  - Set res_valid=1 and go to DONE.
- DONE:
  - Hold res_* stable while res_ready=0.
  - On res_ready=1, the result is consumed at that edge. res_valid drops next cycle unless a new grant occurs in the same cycle; in that case res_valid still drops (the state is CONV), and it rises again one cycle later.
- Latency: operand handshake edge to res_valid high is 2 edges.
- Peak throughput is one result every 2 cycles.
- Conversion (operand d):
  - d==0: result 0x00000000, plost=0.
  - Otherwise sign=d[31] and mag = sign ? -d : d, taken modulo 2^32. For 0x80000000, mag=0x80000000.
  - lz = leading-zero count of mag (0..31). Shift mag left by lz into norm[31:0].
  - exponent = 158 - lz (8 bits); fraction = norm[30:8], truncated with no rounding.
  - plost = |norm[7:0].
  - Result is {sign, exponent, fraction}.
- plost_cnt:
  - Increments by 1 at the edge where a result with res_plost=1 is consumed (res_valid && res_ready).
  - Saturates at all-ones.
  - plost_clr=1 clears it to 0 and has priority over a same-cycle increment.
- busy = (state != IDLE).
- A requester that drops req_valid before being granted loses no state; the arbiter simply re-evaluates each accepting cycle.

Test Plan:
- Single request, requester 0, d=0x00000001, res_ready=1 -> res_data=0x3F800000, res_plost=0, res_tag=0, res_valid high 2 edges after the handshake.
- Boundary values, each on requester 1:
  - d=0xFFFFFFFF -> 0xBF800000, plost 0.
  - d=0x80000000 -> 0xCF000000, plost 0.
  - d=0 -> 0x00000000, plost 0.
  - d=0x7FFFFFFF -> 0x4EFFFFFF, plost 1.
- All 4 req_valid held high, res_ready=1 -> grants in order 0,1,2,3,0; res_tag follows the same order; never two req_ready bits high in one cycle.
- Backpressure: hold res_ready=0 for 5 cycles after result d=0x01000001 -> res_data=0x4B800000, res_plost=1 held stable; req_ready stays 0; on release the next grant is issued in the consume cycle.
- plost_cnt:
  - 3 results with plost=1 -> plost_cnt=3.
  - Assert plost_clr in the same cycle as a 4th plost consume -> plost_cnt=0.
  - With CNT_W=2, 5 plost results -> plost_cnt saturates at 3.
- Reset asserted while in CONV with requester 2 granted -> next cycle res_valid=0, busy=0, rr_ptr=0; a subsequent request from requester 2 converts normally.
